// File: rtl/kb_fifo_arbiter.sv
// Keyboard scancode FIFO sharing one single-port RAM between a never-stalled
// keyboard writer and a CPU pop path. The writer always wins the RAM port.
module kb_fifo_arbiter #(
   parameter int unsigned DEPTH        = 128,
   parameter int unsigned ADDR_W       = 7,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic [7:0]        kb_scancode_in,
   input  logic              kb_valid_in,
   input  logic              cpu_rd_req_in,
   input  logic              cpu_clr_in,
   output logic [ADDR_W-1:0] ram_addr_out,
   output logic [7:0]        ram_din_out,
   output logic              ram_we_out,
   input  logic [7:0]        ram_dout_in,
   output logic [7:0]        cpu_data_out,
   output logic              cpu_data_valid_out,
   output logic [ADDR_W:0]   count_out,
   output logic              empty_out,
   output logic              full_out,
   output logic              overflow_out,
   output logic              rd_busy_out
);

   localparam int unsigned CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(READ_LATENCY - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} rd_state_e;

   rd_state_e         state_q;
   logic [ADDR_W-1:0] wr_ptr_q;
   logic [ADDR_W-1:0] rd_ptr_q;
   logic [ADDR_W:0]   count_q;
   logic              overflow_q;
   logic [CNT_W-1:0]  wait_cnt_q;
   logic [7:0]        data_q;

   logic              wr_accept;
   logic              rd_issue;
   logic [ADDR_W-1:0] wr_ptr_nxt;
   logic [ADDR_W-1:0] rd_ptr_nxt;

   assign empty_out = (count_q == '0);
   assign full_out  = (count_q == FULL_CNT);

   // Reset is folded in so the RAM never sees a write strobe while held in reset.
   assign wr_accept = kb_valid_in && !full_out && !cpu_clr_in && !rst_in;
   // A read only goes out in a cycle the writer leaves the port free.
   assign rd_issue  = (state_q == StIssue) && !wr_accept;

   assign wr_ptr_nxt = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + ADDR_W'(1);
   assign rd_ptr_nxt = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + ADDR_W'(1);

   // RAM port mux: read address only on an issue cycle, otherwise the write pointer.
   always_comb begin
      ram_we_out   = wr_accept;
      ram_din_out  = kb_scancode_in;
      ram_addr_out = rd_issue ? rd_ptr_q : wr_ptr_q;
   end

   assign cpu_data_out       = data_q;
   assign cpu_data_valid_out = (state_q == StDone);
   assign rd_busy_out        = (state_q != StIdle);
   assign count_out          = count_q;
   assign overflow_out       = overflow_q;

   // Pointers, occupancy and sticky overflow; clear beats every other event.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (cpu_clr_in) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (wr_accept) wr_ptr_q <= wr_ptr_nxt;
         if (rd_issue)  rd_ptr_q <= rd_ptr_nxt;
         if (wr_accept && !rd_issue) begin
            count_q <= count_q + (ADDR_W + 1)'(1);
         end else if (rd_issue && !wr_accept) begin
            count_q <= count_q - (ADDR_W + 1)'(1);
         end
         if (kb_valid_in && full_out) overflow_q <= 1'b1;
      end
   end

   // Pop FSM: issue the read when the port is free, wait out RAM latency, pulse valid.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= StIdle;
         wait_cnt_q <= '0;
         data_q     <= 8'h00;
      end else if (cpu_clr_in) begin
         state_q <= StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cpu_rd_req_in) begin
                  if (empty_out) begin
                     data_q  <= 8'h00;
                     state_q <= StDone;
                  end else begin
                     state_q <= StIssue;
                  end
               end
            end
            StIssue: begin
               if (rd_issue) begin
                  wait_cnt_q <= WAIT_INIT;
                  state_q    <= StWait;
               end
            end
            StWait: begin
               if (wait_cnt_q == '0) begin
                  data_q  <= ram_dout_in;
                  state_q <= StDone;
               end else begin
                  wait_cnt_q <= wait_cnt_q - CNT_W'(1);
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_kb_fifo_arbiter.sv
// Directed bench for kb_fifo_arbiter with a behavioural 2-cycle single-port RAM.
module tb_kb_fifo_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] kb_scancode = 8'h00;
   logic       kb_valid = 1'b0;
   logic       cpu_rd_req = 1'b0;
   logic       cpu_clr = 1'b0;
   logic [6:0] ram_addr;
   logic [7:0] ram_din;
   logic       ram_we;
   logic [7:0] ram_dout;
   logic [7:0] cpu_data;
   logic       cpu_data_valid;
   logic [7:0] count;
   logic       empty;
   logic       full;
   logic       overflow;
   logic       rd_busy;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] mem [128];
   logic [7:0] rd_pipe;

   kb_fifo_arbiter #(
      .DEPTH       (128),
      .ADDR_W      (7),
      .READ_LATENCY(2)
   ) dut (
      .clk_in            (clk),
      .rst_in            (rst),
      .kb_scancode_in    (kb_scancode),
      .kb_valid_in       (kb_valid),
      .cpu_rd_req_in     (cpu_rd_req),
      .cpu_clr_in        (cpu_clr),
      .ram_addr_out      (ram_addr),
      .ram_din_out       (ram_din),
      .ram_we_out        (ram_we),
      .ram_dout_in       (ram_dout),
      .cpu_data_out      (cpu_data),
      .cpu_data_valid_out(cpu_data_valid),
      .count_out         (count),
      .empty_out         (empty),
      .full_out          (full),
      .overflow_out      (overflow),
      .rd_busy_out       (rd_busy)
   );

   always #5 clk = ~clk;

   // Single-port RAM: data for an address issued in cycle N is on ram_dout in cycle N+2.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      rd_pipe  <= mem[ram_addr];
      ram_dout <= rd_pipe;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] v);
      kb_valid    = 1'b1;
      kb_scancode = v;
      tick();
      kb_valid    = 1'b0;
   endtask

   // Request a pop, wait (bounded) for the valid pulse, check data, latency, pulse width.
   task automatic pop_check(input string tag, input logic [7:0] exp_data, input int exp_lat);
      int lat;
      cpu_rd_req = 1'b1;
      tick();
      cpu_rd_req = 1'b0;
      lat = 1;
      while (!cpu_data_valid && lat < 40) begin
         tick();
         lat++;
      end
      check({tag, "_valid"}, 32'(cpu_data_valid), 32'd1);
      check({tag, "_data"}, 32'(cpu_data), 32'(exp_data));
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      tick();
      check({tag, "_pulse1"}, 32'(cpu_data_valid), 32'd0);
   endtask

   initial begin
      int lat;
      bit seen;

      // Asynchronous reset, observed before the first clock edge.
      #2 rst = 1'b1;
      #1;
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_busy", 32'(rd_busy), 32'd0);
      check("rst_valid", 32'(cpu_data_valid), 32'd0);
      check("rst_we", 32'(ram_we), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_data", 32'(cpu_data), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      check("idle_addr_is_wr_ptr", 32'(ram_addr), 32'd0);

      // Three writes then three pops in order.
      kb_valid    = 1'b1;
      kb_scancode = 8'h1C;
      #1;
      check("wr_we", 32'(ram_we), 32'd1);
      check("wr_addr", 32'(ram_addr), 32'd0);
      check("wr_din", 32'(ram_din), 32'h1C);
      tick();
      kb_valid = 1'b0;
      push(8'h32);
      push(8'h21);
      check("three_count", 32'(count), 32'd3);
      check("three_addr", 32'(ram_addr), 32'd3);
      pop_check("pop0", 8'h1C, 4);
      pop_check("pop1", 8'h32, 4);
      pop_check("pop2", 8'h21, 4);
      check("three_count_end", 32'(count), 32'd0);
      check("three_empty_end", 32'(empty), 32'd1);

      // Pop on empty: immediate 0x00.
      pop_check("empty_pop", 8'h00, 1);
      check("empty_pop_count", 32'(count), 32'd0);

      // Writer holds ISSUE for three cycles (pointers at 3).
      push(8'hAA);
      cpu_rd_req = 1'b1;
      tick();
      cpu_rd_req  = 1'b0;
      kb_valid    = 1'b1;
      kb_scancode = 8'hB1;
      #1;
      check("contend_busy", 32'(rd_busy), 32'd1);
      check("contend_we", 32'(ram_we), 32'd1);
      check("contend_addr", 32'(ram_addr), 32'd4);
      tick();
      kb_scancode = 8'hB2;
      tick();
      kb_scancode = 8'hB3;
      tick();
      kb_valid = 1'b0;
      #1;
      check("issue_we", 32'(ram_we), 32'd0);
      check("issue_addr", 32'(ram_addr), 32'd3);
      lat = 4;
      while (!cpu_data_valid && lat < 40) begin
         tick();
         lat++;
      end
      check("contend_data", 32'(cpu_data), 32'hAA);
      check("contend_lat", 32'(lat), 32'd7);
      check("contend_count", 32'(count), 32'd3);
      tick();
      pop_check("contend_b1", 8'hB1, 4);
      pop_check("contend_b2", 8'hB2, 4);
      pop_check("contend_b3", 8'hB3, 4);

      // Fill to full, overflow on the 129th (pointers at 7, so this wraps).
      for (int i = 0; i < 128; i++) push(8'(i * 3 + 1));
      check("fill_full", 32'(full), 32'd1);
      check("fill_count", 32'(count), 32'd128);
      check("fill_no_ovf", 32'(overflow), 32'd0);
      kb_valid    = 1'b1;
      kb_scancode = 8'hEE;
      #1;
      check("drop_we", 32'(ram_we), 32'd0);
      tick();
      kb_valid = 1'b0;
      check("drop_ovf", 32'(overflow), 32'd1);
      check("drop_count", 32'(count), 32'd128);
      for (int i = 0; i < 128; i++) pop_check("fill_pop", 8'(i * 3 + 1), 4);
      check("drain_empty", 32'(empty), 32'd1);
      check("ovf_sticky", 32'(overflow), 32'd1);

      // Clear during WAIT aborts the pop; same-cycle write is dropped.
      for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
      cpu_rd_req = 1'b1;
      tick();
      cpu_rd_req = 1'b0;
      tick();
      check("clr_in_wait_busy", 32'(rd_busy), 32'd1);
      cpu_clr     = 1'b1;
      kb_valid    = 1'b1;
      kb_scancode = 8'h99;
      tick();
      cpu_clr  = 1'b0;
      kb_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (cpu_data_valid) seen = 1'b1;
         tick();
      end
      check("clr_no_valid", 32'(seen), 32'd0);
      check("clr_count", 32'(count), 32'd0);
      check("clr_empty", 32'(empty), 32'd1);
      check("clr_ovf", 32'(overflow), 32'd0);
      check("clr_busy", 32'(rd_busy), 32'd0);
      check("clr_addr", 32'(ram_addr), 32'd0);

      // Wrap-around from pointers at 0.
      for (int i = 0; i < 100; i++) push(8'(i + 8'h10));
      for (int i = 0; i < 100; i++) pop_check("wrap_a", 8'(i + 8'h10), 4);
      for (int i = 0; i < 60; i++) push(8'(i * 5 + 7));
      check("wrap_count", 32'(count), 32'd60);
      check("wrap_wr_ptr", 32'(ram_addr), 32'd32);
      for (int i = 0; i < 60; i++) pop_check("wrap_b", 8'(i * 5 + 7), 4);
      check("wrap_empty", 32'(empty), 32'd1);

      // Reset mid-pop: outputs drop without a clock edge.
      push(8'h77);
      cpu_rd_req = 1'b1;
      tick();
      cpu_rd_req = 1'b0;
      tick();
      #2 rst = 1'b1;
      #1;
      check("rstpop_busy", 32'(rd_busy), 32'd0);
      check("rstpop_valid", 32'(cpu_data_valid), 32'd0);
      check("rstpop_count", 32'(count), 32'd0);
      check("rstpop_empty", 32'(empty), 32'd1);
      tick();
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (cpu_data_valid) seen = 1'b1;
         tick();
      end
      check("rstpop_no_valid", 32'(seen), 32'd0);
      push(8'h55);
      pop_check("after_rst", 8'h55, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/kb_fifo_arbiter.md
KB_FIFO_ARBITER -- requirements
Module: kb_fifo_arbiter

Interface
REQ-001 Parameter DEPTH, default 128, SHALL set the number of scancode entries in the shared RAM.
REQ-002 Parameter ADDR_W, default 7, SHALL set the RAM address width, equal to log2(DEPTH).
REQ-003 Parameter READ_LATENCY, default 2, SHALL set the cycles from RAM address issue to valid ram_dout_in.
REQ-004 clk_in  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst_in  in  1  SHALL be the reset: asynchronous, active-high.
REQ-006 kb_scancode_in  in  8  SHALL carry the keyboard scancode.
REQ-007 kb_valid_in  in  1  SHALL be a write strobe; one scancode per high cycle; it is never stalled.
REQ-008 cpu_rd_req_in  in  1  SHALL be a one-cycle pop request from the MMIO decoder.
REQ-009 cpu_clr_in  in  1  SHALL be a one-cycle clear request.
REQ-010 ram_addr_out  out  ADDR_W  SHALL carry the single-port RAM address.
REQ-011 ram_din_out  out  8  SHALL carry the RAM write data.
REQ-012 ram_we_out  out  1  SHALL be the RAM write enable.
REQ-013 ram_dout_in  in  8  SHALL carry the RAM read data.
REQ-014 cpu_data_out  out  8  SHALL carry the popped scancode.
REQ-015 cpu_data_valid_out  out  1  SHALL be a one-cycle pulse qualifying cpu_data_out.
REQ-016 count_out  out  ADDR_W+1  SHALL report the number of entries, 0..DEPTH.
REQ-017 The status outputs SHALL be:
- empty_out, full_out: 1 bit each, combinational from count_out.
- overflow_out: 1 bit, sticky dropped-write flag.
- rd_busy_out: 1 bit, high while a pop is outstanding.

Function
REQ-018 The block SHALL run a circular FIFO over the RAM using wr_ptr and rd_ptr (ADDR_W bits each); both SHALL wrap from DEPTH-1 to 0.
REQ-019 An accepted write SHALL occur on any kb_valid_in cycle with !full_out and !cpu_clr_in.
- Write port, combinational: ram_we_out=1, ram_addr_out=wr_ptr, ram_din_out=kb_scancode_in.
- Next edge: wr_ptr+1.
REQ-020 A write with full_out=1 SHALL be dropped: no RAM write, no pointer or count change, overflow_out set to 1 at the next edge.
REQ-021 The read FSM SHALL have states IDLE, ISSUE, WAIT and DONE.
REQ-022 IDLE with cpu_rd_req_in=1 and empty_out=0 SHALL go to ISSUE.
REQ-023 IDLE with cpu_rd_req_in=1 and empty_out=1 SHALL go to DONE with the data register loaded with 0x00; no pointer change.
REQ-024 ISSUE SHALL give the RAM port to the writer: if a write is accepted that cycle, the FSM SHALL stay in ISSUE.
REQ-025 ISSUE with no accepted write SHALL issue the read and go to WAIT.
- Drives ram_addr_out=rd_ptr, ram_we_out=0.
- Next edge: rd_ptr+1, wait counter loaded with READ_LATENCY-1.
REQ-026 WAIT SHALL decrement the counter each cycle; at counter 0, it SHALL capture ram_dout_in into the data register and go to DONE.
REQ-027 DONE SHALL assert cpu_data_valid_out for exactly one cycle, then go to IDLE.
REQ-028 rd_busy_out SHALL be 1 in ISSUE, WAIT and DONE.
REQ-029 cpu_rd_req_in outside IDLE SHALL be ignored.
REQ-030 Uncontended pop latency SHALL be: request at cycle T, cpu_data_valid_out at cycle T+2+READ_LATENCY (T+4 at default).
REQ-031 count_out SHALL update at each edge:
- +1 on an accepted write.
- -1 on a read issue.
- unchanged when both occur in the same cycle.
REQ-032 With no write or read issue in a cycle, ram_addr_out SHALL equal wr_ptr and ram_we_out SHALL be 0.
REQ-033 cpu_clr_in SHALL take priority over all other events at the next edge.
- wr_ptr, rd_ptr, count_out and overflow_out cleared to 0.
- FSM forced to IDLE; any outstanding pop aborted with no cpu_data_valid_out.
- A same-cycle kb_valid_in is dropped.
REQ-034 cpu_data_out SHALL hold its last value between pulses.

Reset
REQ-035 rst_in=1 SHALL immediately, without waiting for a clock edge, force the following values, held until rst_in falls:
- wr_ptr=0, rd_ptr=0, count_out=0, FSM=IDLE, data register=0x00.
- empty_out=1, full_out=0, overflow_out=0, rd_busy_out=0, cpu_data_valid_out=0, ram_we_out=0.
REQ-036 Reset asserted during a pop SHALL abort the pop; RAM contents SHALL NOT be required to clear.

Verification
REQ-037 Write 0x1C, 0x32, 0x21, then three pops -> data 0x1C, 0x32, 0x21 in order, each valid 4 cycles after its request; count_out goes 3 to 0.
REQ-038 Pop when empty -> cpu_data_valid_out at T+1 with 0x00; count_out stays 0; pointers unchanged.
REQ-039 Write 129 scancodes with no pops -> full_out=1 after the 128th; the 129th is dropped and overflow_out=1; 128 pops return the first 128 values in order.
REQ-040 Pop request with kb_valid_in held high for 3 cycles during ISSUE -> ISSUE held 3 cycles, all 3 writes land, popped value is correct, valid at T+7.
REQ-041 Fill to 5 entries, start a pop, assert cpu_clr_in in WAIT -> no cpu_data_valid_out; count_out=0, empty_out=1, overflow_out=0.
REQ-042 Wrap-around: 100 writes, 100 pops, 60 writes, 60 pops -> data in order across the wr_ptr/rd_ptr wrap at 127 to 0.
